bsg_fifo_1r1w_rolly_mc: RTL and testbench
=========================================

Name: bsg_fifo_1r1w_rolly_mc

Overview:
- Next-generation rollback FIFO with three pointers: write (wptr), read (rptr) and commit (cptr).
- Entries stay between cptr and rptr after they are read, until they are committed.
- roll rewinds rptr to the commit point so speculatively read entries replay. clr squashes everything written but not yet read.
- Adds over the previous generation: multi-entry commit per cycle, any els_p (not only powers of two), occupancy/credit outputs, and defined same-cycle roll+clr behaviour.
- Used between a speculative producer/consumer pair, e.g. a replayable command queue.

Parameters:
- width_p, "inv", payload width in bits.
- els_p, "inv", entry count; any integer >= 2.
- commit_width_p, 1, maximum entries committed in one cycle (1..els_p).
- ready_THEN_valid_p, 0, if 1 the producer asserts v_i only when ready_o=1, and enq = v_i; else enq = v_i & ready_o.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-low. State is reset on the clk_i edge at which reset_i=0.
- clr_v_i  in  1  squash all unread entries.
- roll_v_i  in  1  rewind rptr to the commit point.
- commit_cnt_i  in  clog2(commit_width_p+1)  number of read entries to retire this cycle.
- data_i  in  width_p  write data.
- v_i  in  1  write valid.
- ready_o  out  1  FIFO can accept a write.
- data_o  out  width_p  entry at rptr, combinational.
- v_o  out  1  data_o valid.
- yumi_i  in  1  consumer takes data_o; legal only when v_o=1.
- num_unread_o  out  clog2(els_p+1)  wptr-rptr.
- num_uncommitted_o  out  clog2(els_p+1)  rptr-cptr.
- num_free_o  out  clog2(els_p+1)  els_p-(wptr-cptr).

Behaviour:
- Pointers: range 0..2*els_p-1. Address = ptr mod els_p, derived from the pointer without a divider (use a wrap bit plus an index counter). All differences are computed modulo 2*els_p.
- Invariant: cptr <= rptr <= wptr (modular order); wptr-cptr <= els_p.
- empty = (rptr==wptr); full = (wptr-cptr == els_p).
- ready_o = reset_i & ~clr_v_i & ~full.
- v_o = reset_i & ~roll_v_i & ~empty.
- Reset (reset_i=0 at edge): all pointers 0. While reset_i=0: ready_o=0, v_o=0, all counts 0 except num_free_o=els_p.
  - First cycle after release: ready_o=1, v_o=0.
  - Memory contents are undefined and never observable.
- Write: enq writes data_i at wptr. The write is visible on data_o the next cycle at the earliest (no write-to-read bypass).
- Read: yumi_i=1 advances rptr by 1. Zero-latency: data_o reflects the current rptr combinationally.
- Commit: cptr_n = cptr + commit_cnt_i.
  - Legal only if commit_cnt_i <= (rptr-cptr) + yumi_i. A same-cycle read may be committed.
  - Violation is an assertion error; RTL then saturates cptr_n at rptr_n.
- Roll: rptr_n = cptr + commit_cnt_i. yumi_i is ignored (v_o=0 makes it illegal). Writes are unaffected.
- Clr: wptr_n = rptr_n. enq is suppressed (ready_o=0), so v_i is dropped even when ready_THEN_valid_p=1.
- roll+clr same cycle: rptr_n = wptr_n = cptr + commit_cnt_i; FIFO becomes empty of uncommitted state.
- Freed slots: slots freed by a commit are visible in ready_o/num_free_o the following cycle, not combinationally.
- Full plus commit same cycle: no write (ready_o=0); ready_o rises next cycle.
- Counts: registered-pointer differences (current cycle), not next-state values.
- Wrap: pointers wrap from 2*els_p-1 to 0. A multi-entry jump that crosses the wrap must produce the correct modular result.
- Assertions (simulation only): yumi_i & ~v_o; v_i & ~ready_o when ready_THEN_valid_p=1; commit overflow; reset_i unknown.

Test Plan:
- Reset then fill: els_p=5, width_p=8. Hold reset_i=0 for 3 cycles (ready_o=0). Release and write 0x10..0x14 -> ready_o=0 after the 5th write, num_free_o=0, data_o=0x10, num_unread_o=5.
- Read and roll replay: read 3 entries, commit 1, assert roll_v_i -> v_o=0 that cycle. Next cycle data_o=0x11, num_uncommitted_o=0, num_unread_o=4.
- Multi-commit with wrap: els_p=5, commit_width_p=3. Run 40 write/read/commit-by-3 cycles so pointers cross 9->0 repeatedly -> data order matches a scoreboard, num_free_o is never negative, no assertion fires.
- Clr with same-cycle yumi: 4 unread entries; assert clr_v_i with yumi_i and v_i=1 -> write dropped. Next cycle v_o=0, num_unread_o=0, num_uncommitted_o incremented by 1.
- roll+clr same cycle with commit_cnt_i=2 and rptr-cptr=3 -> next cycle wptr=rptr=cptr, all counts 0, num_free_o=els_p, ready_o=1.
- Full+commit: FIFO full, commit 2 -> ready_o=0 that cycle, 1 next cycle. Mid-operation reset_i=0 -> pointers 0, v_o=0, ready_o=0 until release.

Source files
------------

// File: rtl/bsg_fifo_1r1w_rolly_mc_if.sv
// rtl/bsg_fifo_1r1w_rolly_mc_if.sv - handshake and status bundle for the rollback FIFO
interface bsg_fifo_1r1w_rolly_mc_if #(
    parameter int width_p        = 8,
    parameter int els_p          = 5,
    parameter int commit_width_p = 1
);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int cc_w  = $clog2(commit_width_p + 1);

    logic               clr_v_i;
    logic               roll_v_i;
    logic [cc_w-1:0]    commit_cnt_i;
    logic [width_p-1:0] data_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               yumi_i;
    logic [cnt_w-1:0]   num_unread_o;
    logic [cnt_w-1:0]   num_uncommitted_o;
    logic [cnt_w-1:0]   num_free_o;

    // FIFO side
    modport slave (
        input  clr_v_i, roll_v_i, commit_cnt_i, data_i, v_i, yumi_i,
        output ready_o, data_o, v_o, num_unread_o, num_uncommitted_o, num_free_o
    );

    // producer/consumer side
    modport master (
        output clr_v_i, roll_v_i, commit_cnt_i, data_i, v_i, yumi_i,
        input  ready_o, data_o, v_o, num_unread_o, num_uncommitted_o, num_free_o
    );
endinterface

// File: rtl/bsg_fifo_1r1w_rolly_mc.sv
// rtl/bsg_fifo_1r1w_rolly_mc.sv - rollback FIFO with write/read/commit pointers and multi-entry commit
module bsg_fifo_1r1w_rolly_mc #(
    parameter int width_p            = 8,
    parameter int els_p              = 5,
    parameter int commit_width_p     = 1,
    parameter int ready_THEN_valid_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bsg_fifo_1r1w_rolly_mc_if.slave    bus
);
    localparam int idx_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    // wide enough to hold 4*els_p-1 so modular sums never overflow
    localparam int dw    = idx_w + 2;
    localparam logic [dw-1:0] els_c     = dw'(els_p);
    localparam logic [dw-1:0] two_els_c = dw'(2 * els_p);

    // pointer = wrap*els_p + idx, range 0..2*els_p-1; idx is the memory address
    typedef struct packed {
        logic             wrap;
        logic [idx_w-1:0] idx;
    } ptr_t;

    function automatic logic [dw-1:0] ptr_val(input ptr_t p);
        return dw'(p.idx) + (p.wrap ? els_c : '0);
    endfunction

    // a - b modulo 2*els_p
    function automatic logic [dw-1:0] ptr_diff(input ptr_t a, input ptr_t b);
        logic [dw-1:0] va;
        logic [dw-1:0] vb;
        va = ptr_val(a);
        vb = ptr_val(b);
        return (va >= vb) ? (va - vb) : (va + two_els_c - vb);
    endfunction

    // p + k for k <= els_p: one conditional subtract replaces the modulo
    function automatic ptr_t ptr_add(input ptr_t p, input logic [dw-1:0] k);
        logic [dw-1:0] s;
        ptr_t          r;
        s = dw'(p.idx) + k;
        if (s >= els_c) begin
            r.idx  = idx_w'(s - els_c);
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = idx_w'(s);
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    ptr_t wptr_r, rptr_r, cptr_r;
    ptr_t wptr_n, rptr_n, cptr_n;

    logic [width_p-1:0] mem [els_p];

    logic [dw-1:0] unread, uncommitted, in_use;
    logic [dw-1:0] avail, commit_req, commit_eff;
    logic          empty, full, enq, deq;

    assign unread      = ptr_diff(wptr_r, rptr_r);
    assign uncommitted = ptr_diff(rptr_r, cptr_r);
    assign in_use      = ptr_diff(wptr_r, cptr_r);
    assign empty       = (unread == '0);
    assign full        = (in_use == els_c);

    assign bus.ready_o = reset_i & ~bus.clr_v_i & ~full;
    assign bus.v_o     = reset_i & ~bus.roll_v_i & ~empty;
    assign bus.data_o  = mem[rptr_r.idx];

    // clr drops the write even if the producer trusted an earlier ready
    assign enq = (ready_THEN_valid_p != 0) ? (bus.v_i & reset_i & ~bus.clr_v_i)
                                           : (bus.v_i & bus.ready_o);
    assign deq = bus.yumi_i & bus.v_o;

    // an over-large commit is clamped so cptr never passes the new rptr
    assign commit_req = dw'(bus.commit_cnt_i);
    assign avail      = uncommitted + dw'(deq);
    assign commit_eff = (commit_req > avail) ? avail : commit_req;

    assign bus.num_unread_o      = reset_i ? cnt_w'(unread) : '0;
    assign bus.num_uncommitted_o = reset_i ? cnt_w'(uncommitted) : '0;
    assign bus.num_free_o        = reset_i ? cnt_w'(els_c - in_use) : cnt_w'(els_p);

    // next pointers: roll rewinds to the new commit point, clr collapses wptr onto rptr
    always_comb begin
        cptr_n = ptr_add(cptr_r, commit_eff);
        rptr_n = ptr_add(rptr_r, dw'(deq));
        wptr_n = ptr_add(wptr_r, dw'(enq));
        if (bus.roll_v_i) begin
            rptr_n = cptr_n;
        end
        if (bus.clr_v_i) begin
            wptr_n = rptr_n;
        end
    end

    // pointer registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // storage write; read port is the combinational mux on rptr
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_r.idx] <= bus.data_i;
        end
    end

    // protocol checks, ignored by synthesis
    always @(posedge clk_i) begin
        assert (!$isunknown(reset_i)) else $error("rolly: reset_i unknown");
        if (reset_i === 1'b1) begin
            assert (!(bus.yumi_i && !bus.v_o)) else $error("rolly: yumi_i while v_o=0");
            if (ready_THEN_valid_p != 0) begin
                assert (!(bus.v_i && !bus.ready_o)) else $error("rolly: v_i while ready_o=0");
            end
            assert (commit_req <= avail) else $error("rolly: commit overflow");
        end
    end
endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_mc.sv
// tb/tb_bsg_fifo_1r1w_rolly_mc.sv - table-driven and model-checked bench for the rollback FIFO
module tb_bsg_fifo_1r1w_rolly_mc;
    localparam int ELS = 5;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bsg_fifo_1r1w_rolly_mc_if #(.width_p(8), .els_p(ELS), .commit_width_p(CW)) bus ();

    bsg_fifo_1r1w_rolly_mc #(
        .width_p(8), .els_p(ELS), .commit_width_p(CW), .ready_THEN_valid_p(0)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       rst, clr, roll;
        logic [1:0] cc;
        logic       v;
        logic [7:0] d;
        logic       y;
        logic       e_rdy, e_v;
        int         e_unread, e_uncom, e_free;
        logic       dchk;
        logic [7:0] e_data;
    } vec_t;

    vec_t tab[$];

    // reference model: uncommitted-or-unread entries oldest first, mrd of them already read
    logic [7:0] mq[$];
    int         mrd = 0;

    function automatic vec_t mk(input logic r, c, ro, input int cc, input logic v,
                                input int d, input logic y, input logic rdy, vo,
                                input int un, uc, fr, input logic dchk, input int dat);
        vec_t t;
        t.rst = r; t.clr = c; t.roll = ro; t.cc = 2'(cc); t.v = v; t.d = 8'(d); t.y = y;
        t.e_rdy = rdy; t.e_v = vo; t.e_unread = un; t.e_uncom = uc; t.e_free = fr;
        t.dchk = dchk; t.e_data = 8'(dat);
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, c, ro, input int cc, input logic v,
                         input logic [7:0] d, input logic y);
        rst = r;
        bus.clr_v_i = c;
        bus.roll_v_i = ro;
        bus.commit_cnt_i = 2'(cc);
        bus.v_i = v;
        bus.data_i = d;
        bus.yumi_i = y;
    endtask

    function automatic logic m_vo(input logic ro);
        return !ro && (mrd < mq.size());
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // one clock of stimulus checked against the queue model, then the model advances
    task automatic mcycle(input string tag, input logic r, c, ro, input int cc,
                          input logic v, input logic [7:0] d, input logic y);
        logic e_rdy, e_v;
        int   e_un, e_uc, e_fr, eff, rt;
        @(negedge clk);
        drive(r, c, ro, cc, v, d, y);
        #1;
        if (!r) begin
            e_rdy = 0; e_v = 0; e_un = 0; e_uc = 0; e_fr = ELS;
        end else begin
            e_rdy = !c && (mq.size() < ELS);
            e_v   = m_vo(ro);
            e_un  = mq.size() - mrd;
            e_uc  = mrd;
            e_fr  = ELS - mq.size();
        end
        check({tag, "_ready"}, 32'(bus.ready_o), 32'(e_rdy));
        check({tag, "_v"}, 32'(bus.v_o), 32'(e_v));
        check({tag, "_unread"}, 32'(bus.num_unread_o), e_un);
        check({tag, "_uncom"}, 32'(bus.num_uncommitted_o), e_uc);
        check({tag, "_free"}, 32'(bus.num_free_o), e_fr);
        if (r && mrd < mq.size()) check({tag, "_data"}, 32'(bus.data_o), 32'(mq[mrd]));
        if (!r) begin
            mq.delete();
            mrd = 0;
        end else begin
            if (v && e_rdy) mq.push_back(d);
            eff = imin(cc, mrd + ((y && e_v) ? 1 : 0));
            rt  = ro ? eff : mrd + ((y && e_v) ? 1 : 0);
            if (c) while (mq.size() > rt) void'(mq.pop_back());
            repeat (eff) void'(mq.pop_front());
            mrd = rt - eff;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 8'h00, 0);

        // rst clr roll cc v d y | rdy v unread uncom free dchk data
        repeat (3) tab.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0,5,0,0));
        tab.push_back(mk(1,0,0,0,1,'h10,0,  1,0,0,0,5,0,0));
        tab.push_back(mk(1,0,0,0,1,'h11,0,  1,1,1,0,4,1,'h10));
        tab.push_back(mk(1,0,0,0,1,'h12,0,  1,1,2,0,3,1,'h10));
        tab.push_back(mk(1,0,0,0,1,'h13,0,  1,1,3,0,2,1,'h10));
        tab.push_back(mk(1,0,0,0,1,'h14,0,  1,1,4,0,1,1,'h10));
        tab.push_back(mk(1,0,0,0,0,0,0,     0,1,5,0,0,1,'h10));
        tab.push_back(mk(1,0,0,0,0,0,1,     0,1,5,0,0,1,'h10));
        tab.push_back(mk(1,0,0,0,0,0,1,     0,1,4,1,0,1,'h11));
        tab.push_back(mk(1,0,0,0,0,0,1,     0,1,3,2,0,1,'h12));
        tab.push_back(mk(1,0,1,1,0,0,0,     0,0,2,3,0,1,'h13));
        tab.push_back(mk(1,0,0,0,0,0,0,     1,1,4,0,1,1,'h11));
        tab.push_back(mk(1,1,0,0,1,'hAA,1,  0,1,4,0,1,1,'h11));
        tab.push_back(mk(1,0,0,0,1,'h20,0,  1,0,0,1,4,0,0));
        tab.push_back(mk(1,0,0,0,1,'h21,0,  1,1,1,1,3,1,'h20));
        tab.push_back(mk(1,0,0,0,0,0,1,     1,1,2,1,2,1,'h20));
        tab.push_back(mk(1,0,0,0,1,'h22,1,  1,1,1,2,2,1,'h21));
        tab.push_back(mk(1,1,1,2,0,0,0,     0,0,1,3,1,1,'h22));
        tab.push_back(mk(1,0,0,0,1,'h30,0,  1,0,0,0,5,0,0));
        tab.push_back(mk(1,0,0,0,1,'h31,0,  1,1,1,0,4,1,'h30));
        tab.push_back(mk(1,0,0,0,1,'h32,0,  1,1,2,0,3,1,'h30));
        tab.push_back(mk(1,0,0,0,1,'h33,0,  1,1,3,0,2,1,'h30));
        tab.push_back(mk(1,0,0,0,1,'h34,0,  1,1,4,0,1,1,'h30));
        tab.push_back(mk(1,0,0,0,0,0,1,     0,1,5,0,0,1,'h30));
        tab.push_back(mk(1,0,0,0,0,0,1,     0,1,4,1,0,1,'h31));
        tab.push_back(mk(1,0,0,2,1,'hEE,0,  0,1,3,2,0,1,'h32));
        tab.push_back(mk(1,0,0,0,0,0,0,     1,1,3,0,2,1,'h32));
        tab.push_back(mk(0,0,0,0,0,0,0,     0,0,0,0,5,0,0));
        tab.push_back(mk(0,0,0,0,1,'hFF,0,  0,0,0,0,5,0,0));
        tab.push_back(mk(1,0,0,0,0,0,0,     1,0,0,0,5,0,0));

        foreach (tab[i]) begin
            @(negedge clk);
            drive(tab[i].rst, tab[i].clr, tab[i].roll, int'(tab[i].cc),
                  tab[i].v, tab[i].d, tab[i].y);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(bus.ready_o), 32'(tab[i].e_rdy));
            check($sformatf("vec%0d_v", i), 32'(bus.v_o), 32'(tab[i].e_v));
            check($sformatf("vec%0d_unread", i), 32'(bus.num_unread_o), tab[i].e_unread);
            check($sformatf("vec%0d_uncom", i), 32'(bus.num_uncommitted_o), tab[i].e_uncom);
            check($sformatf("vec%0d_free", i), 32'(bus.num_free_o), tab[i].e_free);
            if (tab[i].dchk)
                check($sformatf("vec%0d_data", i), 32'(bus.data_o), 32'(tab[i].e_data));
        end

        // streaming write/read with commit-by-3 so pointers cross the wrap repeatedly
        mcycle("wrap_rst", 0, 0, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 40; k++) begin
            logic y;
            y = m_vo(0);
            mcycle($sformatf("wrap%0d", k), 1, 0, 0, imin(CW, mrd + (y ? 1 : 0)),
                   1, 8'($urandom), y);
        end

        // randomized traffic including roll, clr and occasional reset
        mcycle("rnd_rst", 0, 0, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 600; k++) begin
            logic r, c, ro, v, y;
            int   cc;
            r  = ($urandom_range(0, 99) != 0);
            c  = ($urandom_range(0, 9) == 0);
            ro = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 3) != 0);
            y  = r && m_vo(ro) && ($urandom_range(0, 2) != 0);
            cc = r ? $urandom_range(0, imin(CW, mrd + (y ? 1 : 0))) : 0;
            mcycle($sformatf("rnd%0d", k), r, c, ro, cc, v, 8'($urandom), y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
